// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures clk_in cycles between rising edges of an asynchronous slow signal
// Continuous measurement with sticky timeout; the first edge after arming only starts the count.
module period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;
  logic             w_rise;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_timeout;
  logic             w_accept;
  logic             w_expire;

  // Synchronizer runs in every state so a level already high on arming is not an edge.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_hist;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_accept     = 1'b0;
    w_expire     = 1'b0;
    if (!enable) begin
      w_state_next = IDLE;
      w_count_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = ARM;
          w_count_next = '0;
        end
        ARM: begin
          if (w_rise) begin
            w_state_next = MEASURE;
            w_count_next = ONE_C;
          end
        end
        MEASURE: begin
          // An edge landing on the timeout count still counts as a valid measurement.
          if (w_rise) begin
            w_accept     = 1'b1;
            w_count_next = ONE_C;
          end else if (r_count == TIMEOUT_C) begin
            w_expire     = 1'b1;
            w_state_next = ARM;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + ONE_C;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_count        <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_count        <= w_count_next;
      r_period_valid <= w_accept;
      if (w_accept) begin
        r_period <= r_count;
      end
      if (w_accept || !enable) begin
        r_timeout <= 1'b0;
      end else if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign timeout      = r_timeout;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - randomized and directed bench for period_meter against a timestamp model
// The model tracks edge timestamps; directed scenarios pin it with hand-computed values.
module tb_period_meter;

  localparam int CNT_W = 16;
  localparam int TMO   = 5000;
  localparam int MAXK  = 100000;

  logic             clk_in = 1'b0;
  logic             reset  = 1'b0;
  logic             enable = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic             busy;

  always #5 clk_in = ~clk_in;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .enable       (enable),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  int n_tot  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: synchronized edge = sig sampled high 2 edges ago, low 3 edges ago.
  typedef enum {M_IDLE, M_ARM, M_MEAS} mmode_t;
  mmode_t m_mode    = M_IDLE;
  bit     samp[0:MAXK-1];
  int     k         = 0;
  int     rst_k     = 0;
  int     t_last    = 0;
  int     m_period  = 0;
  bit     m_valid   = 1'b0;
  bit     m_timeout = 1'b0;

  function automatic bit smp(input int j);
    return (j >= 0 && j >= rst_k && j < MAXK) ? samp[j] : 1'b0;
  endfunction

  always @(posedge clk_in or negedge reset) begin
    bit r;
    int el;
    if (!reset) begin
      m_mode    = M_IDLE;
      m_period  = 0;
      m_valid   = 1'b0;
      m_timeout = 1'b0;
      rst_k     = k;
    end else begin
      if (k < MAXK) samp[k] = sig_in;
      r = smp(k - 2) & ~smp(k - 3);
      m_valid = 1'b0;
      if (!enable) begin
        m_mode    = M_IDLE;
        m_timeout = 1'b0;
      end else begin
        case (m_mode)
          M_IDLE: m_mode = M_ARM;
          M_ARM: if (r) begin
            t_last = k;
            m_mode = M_MEAS;
          end
          default: begin
            el = k - t_last;
            if (r) begin
              m_period  = el;
              m_valid   = 1'b1;
              m_timeout = 1'b0;
              t_last    = k;
            end else if (el == TMO) begin
              m_timeout = 1'b1;
              m_mode    = M_ARM;
            end
          end
        endcase
      end
      k++;
    end
  end

  int n_valid = 0;
  int t_vlast = 0;
  int t_vprev = 0;
  int cyc     = 0;
  bit prev_v  = 1'b0;

  always @(negedge clk_in) begin
    chk("period", period, m_period);
    chk("period_valid", period_valid, m_valid);
    chk("timeout", timeout, m_timeout);
    chk("busy", busy, (m_mode != M_IDLE));
    if (period_valid) begin
      chk("valid_back_to_back", prev_v, 0);
      n_valid++;
      t_vprev = t_vlast;
      t_vlast = cyc;
    end
    prev_v = period_valid;
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic square(input int hi, input int lo, input int reps);
    repeat (reps) begin
      sig_in = 1'b1;
      step(hi);
      sig_in = 1'b0;
      step(lo);
    end
  endtask

  int v0;

  initial begin
    step(3);
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    step(2);
    chk("idle_busy", busy, 0);

    // Square wave 2352/2352: three edges give two results of 4704.
    enable = 1'b1;
    step(10);
    v0 = n_valid;
    square(2352, 2352, 3);
    chk("sq_valids", n_valid - v0, 2);
    chk("sq_period", period, 4704);
    chk("sq_spacing", t_vlast - t_vprev, 4704);

    // One edge then held high: timeout exactly TMO cycles into MEASURE.
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    step(5);
    v0 = n_valid;
    sig_in = 1'b1;
    step(TMO + 2);
    chk("to_not_yet", timeout, 0);
    step(1);
    chk("to_set", timeout, 1);
    chk("to_busy", busy, 1);
    chk("to_period_kept", period, 4704);
    chk("to_no_valid", n_valid - v0, 0);

    // Edge spacing exactly TMO is accepted; TMO+1 times out.
    sig_in = 1'b0;
    step(5);
    sig_in = 1'b1;
    step(5);
    sig_in = 1'b0;
    step(TMO - 5);
    chk("eq_sticky", timeout, 1);
    v0 = n_valid;
    sig_in = 1'b1;
    step(5);
    chk("eq_period", period, TMO);
    chk("eq_timeout_clr", timeout, 0);
    chk("eq_valid", n_valid - v0, 1);
    sig_in = 1'b0;
    step(TMO - 4);
    sig_in = 1'b1;
    step(5);
    chk("over_timeout", timeout, 1);
    chk("over_period", period, TMO);
    chk("over_no_valid", n_valid - v0, 1);

    // Edges 50 apart, enable dropped 20 cycles after an edge.
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    sig_in = 1'b0;
    step(5);
    square(25, 25, 3);
    sig_in = 1'b1;
    step(20);
    enable = 1'b0;
    v0 = n_valid;
    step(3);
    chk("dis_busy", busy, 0);
    step(40);
    chk("dis_no_valid", n_valid - v0, 0);
    chk("dis_period", period, 50);

    // Level already high when enabled: no spurious edge.
    sig_in = 1'b1;
    step(10);
    enable = 1'b1;
    step(10);
    v0 = n_valid;
    sig_in = 1'b0;
    step(5);
    square(5, 5, 4);
    chk("hi_valids", n_valid - v0, 3);
    chk("hi_period", period, 10);

    // Asynchronous reset pulse mid-measurement.
    square(5, 5, 2);
    sig_in = 1'b1;
    step(3);
    #1 reset = 1'b0;
    #1;
    chk("arst_period", period, 0);
    chk("arst_valid", period_valid, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_busy", busy, 0);
    #1 reset = 1'b1;
    sig_in = 1'b0;
    step(4);
    v0 = n_valid;
    square(5, 5, 3);
    chk("arst_valids", n_valid - v0, 2);
    chk("arst_period2", period, 10);

    // Random edges, enable toggles and occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      sig_in = ~sig_in;
      step($urandom_range(1, 30));
    end
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
